load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_if.sv | 22 ++
 rtl/lsu_align.sv | 33 +++
 rtl/load_store_unit.sv | 123 ++++++++++++
 tb/tb_load_store_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and request-legality helpers for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

    // Stores only have signed widths; loads also allow the unsigned byte/half forms
    function automatic logic f3_bad(input logic we, input logic [2:0] f3);
        return we ? !(f3 inside {F3_B, F3_H, F3_W})
                  : !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

    // f3[1:0] encodes the access size for every legal code
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: core-side request/response channel of the load/store unit
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: little-endian load extraction/extension and sub-word store merge
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  b;
    logic [15:0] h;

    // Select the addressed lane, extend for loads, splice the new lane in for stores
    always_comb begin
        b       = word_i[{off_i, 3'b000} +: 8];
        h       = off_i[1] ? word_i[31:16] : word_i[15:0];
        load_o  = funct3_i == F3_B  ? {{24{b[7]}}, b} :
                  funct3_i == F3_BU ? {24'b0, b} :
                  funct3_i == F3_H  ? {{16{h[15]}}, h} :
                  funct3_i == F3_HU ? {16'b0, h} : word_i;
        merge_o = word_i;
        if (funct3_i == F3_B)
            merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
        else if (funct3_i == F3_H)
            merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        else
            merge_o = wdata_i;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer with read-modify-write for sub-word stores
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    lsu_if.slave              bus,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] add,
    output logic [31:0]       write_data,
    input  logic [31:0]       read_data
);

    state_e            state_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic              rd_q;
    logic              wr_q;
    logic              rv_q;
    logic              rf_q;
    logic [ADDR_W-1:0] add_q;
    logic [31:0]       wd_q;
    logic [31:0]       rdata_q;
    logic [31:0]       load_w;
    logic [31:0]       merge_w;
    logic              fault_w;

    assign fault_w = f3_bad(bus.req_we, bus.req_funct3)
                  || misaligned(bus.req_funct3, bus.req_addr[1:0])
                  || (bus.req_addr >> ADDR_W) != 32'd0;

    assign bus.req_ready  = state_q == IDLE;
    assign bus.resp_valid = rv_q;
    assign bus.resp_fault = rf_q;
    assign bus.resp_rdata = rdata_q;
    assign MemRead        = rd_q;
    assign MemWrite       = wr_q;
    assign add            = add_q;
    assign write_data     = wd_q;

    lsu_align u_align (
        .funct3_i (f3_q),
        .off_i    (off_q),
        .word_i   (read_data),
        .wdata_i  (wdata_q),
        .load_o   (load_w),
        .merge_o  (merge_w)
    );

    // Sequencer: every memory strobe and response field is a flop so the memory sees clean levels
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            off_q   <= 2'b0;
            wdata_q <= 32'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rv_q    <= 1'b0;
            rf_q    <= 1'b0;
            add_q   <= '0;
            wd_q    <= 32'b0;
            rdata_q <= 32'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    f3_q    <= bus.req_funct3;
                    off_q   <= bus.req_addr[1:0];
                    wdata_q <= bus.req_wdata;
                    if (fault_w) begin
                        state_q <= RESP;
                        rv_q    <= 1'b1;
                        rf_q    <= 1'b1;
                        rdata_q <= 32'b0;
                    end else if (!bus.req_we || bus.req_funct3 != F3_W) begin
                        state_q <= RD;
                        rd_q    <= 1'b1;
                        add_q   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                    end else begin
                        state_q <= WR;
                        wr_q    <= 1'b1;
                        wd_q    <= bus.req_wdata;
                        add_q   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
                RD: begin
                    rd_q <= 1'b0;
                    if (we_q) begin
                        state_q <= WR;
                        wr_q    <= 1'b1;
                        wd_q    <= merge_w;
                    end else begin
                        state_q <= RESP;
                        rv_q    <= 1'b1;
                        rdata_q <= load_w;
                    end
                end
                WR: begin
                    state_q <= RESP;
                    wr_q    <= 1'b0;
                    wd_q    <= 32'b0;
                    rv_q    <= 1'b1;
                    rdata_q <= 32'b0;
                end
                RESP: begin
                    state_q <= IDLE;
                    rv_q    <= 1'b0;
                    rf_q    <= 1'b0;
                    rdata_q <= 32'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed checks of load_store_unit against an array-based memory model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  add;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [31:0] mem     [128];
    logic [31:0] ref_mem [128];
    int          n_chk = 0;
    int          n_err = 0;

    lsu_if bus ();

    load_store_unit #(.ADDR_W(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .add        (add),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    assign read_data = mem[add[8:2]];

    always @(posedge clk) if (MemWrite) mem[add[8:2]] <= write_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic exp_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (we ? f3 > 3'd2 : !(f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
        return (a % size_of(f3)) != 0 || a >= 32'd512;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [2:0] f3);
        logic [63:0] m;
        m = (64'd1 << (8 * size_of(f3))) - 64'd1;
        return m[31:0];
    endfunction

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rdata_o);
        logic        f;
        logic [31:0] m, word, v, neww;
        int          sh, lat, nrd, nwr, exp_lat;
        f    = exp_fault(we, f3, a);
        m    = lane_mask(f3);
        sh   = 8 * int'(a % 4);
        word = ref_mem[a[8:2]];
        v    = (word >> sh) & m;
        if (!f3[2] && size_of(f3) < 4 && v[8*size_of(f3)-1]) v = v | ~m;
        neww = (word & ~(m << sh)) | ((wd & m) << sh);
        exp_lat = f ? 1 : (we && f3 != 3'd2) ? 3 : 2;
        @(negedge clk);
        chk("ready_idle", bus.req_ready, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1; nrd = 0; nwr = 0;
        while (!bus.resp_valid && lat < 10) begin
            chk("strobe_excl", MemRead & MemWrite, 1'b0);
            nrd += int'(MemRead);
            nwr += int'(MemWrite);
            if (MemRead || MemWrite) chk("add", add, {a[8:2], 2'b00});
            if (MemWrite) chk("write_data", write_data, neww);
            @(negedge clk);
            lat++;
        end
        rdata_o = bus.resp_rdata;
        chk("latency", lat, exp_lat);
        chk("fault", bus.resp_fault, f);
        chk("rdata", bus.resp_rdata, (f || we) ? 32'd0 : v);
        chk("n_read", nrd, (!f && (!we || f3 != 3'd2)) ? 1 : 0);
        chk("n_write", nwr, (!f && we) ? 1 : 0);
        if (!f && we) ref_mem[a[8:2]] = neww;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!bus.resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [31:0] r;
        int          n;
        for (int i = 0; i < 128; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899AABB;
        ref_mem[4] = 32'h8899AABB;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_addr = 32'b0; bus.req_wdata = 32'b0;
        repeat (2) @(posedge clk);
        bus.req_valid = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_fault", bus.resp_fault, 1'b0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_strobes", {MemRead, MemWrite}, 2'b00);
        chk("rst_add", add, 9'd0);
        chk("rst_wdata", write_data, 32'd0);
        bus.req_valid = 1'b0;
        rst = 1'b0;

        do_op(1'b0, 3'b000, 32'h010, 32'h0, r); chk("lb_010", r, 32'hFFFFFFBB);
        do_op(1'b0, 3'b100, 32'h011, 32'h0, r); chk("lbu_011", r, 32'h000000AA);
        do_op(1'b0, 3'b001, 32'h012, 32'h0, r); chk("lh_012", r, 32'hFFFF8899);

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h011; bus.req_wdata = 32'hCC;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort_in_rd", MemRead, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", bus.req_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_write", MemWrite, 1'b0);
            chk("abort_no_resp", bus.resp_valid, 1'b0);
            @(negedge clk);
        end
        chk("abort_mem", mem[4], 32'h8899AABB);

        do_op(1'b1, 3'b000, 32'h011, 32'hCC, r);
        chk("sb_mem", mem[4], 32'h8899CCBB);
        do_op(1'b1, 3'b010, 32'h01C, 32'hDEADBEEF, r);
        do_op(1'b0, 3'b010, 32'h01C, 32'h0, r); chk("lw_01c", r, 32'hDEADBEEF);
        do_op(1'b0, 3'b010, 32'h006, 32'h0, r);
        do_op(1'b1, 3'b001, 32'h003, 32'h1234, r);
        do_op(1'b0, 3'b000, 32'h200, 32'h0, r);
        do_op(1'b0, 3'b011, 32'h000, 32'h0, r);

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h020; bus.req_wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        bus.req_we = 1'b0;
        chk("b2b_busy", bus.req_ready, 1'b0);
        wait_resp(n);
        chk("b2b_sw_lat", n + 1, 2);
        chk("b2b_sw_fault", bus.resp_fault, 1'b0);
        @(negedge clk);
        chk("b2b_idle_ready", bus.req_ready, 1'b1);
        chk("b2b_idle_resp", bus.resp_valid, 1'b0);
        @(negedge clk);
        wait_resp(n);
        bus.req_valid = 1'b0;
        chk("b2b_lw_lat", n + 1, 2);
        chk("b2b_lw_data", bus.resp_rdata, 32'hA5A5_5A5A);
        ref_mem[8] = 32'hA5A5_5A5A;
        @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom_range(0, 511);
            if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(9, 31));
            do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
